kb2piano_poly: RTL and testbench
================================

// Module: kb2piano_poly
// PURPOSE
//  Successor to the single-keycode piano mapper. Consumes the raw PS/2 set-2 scan-code stream
//  and decodes make, break and extended prefixes. It keeps a 12-key held-note bitmap and a
//  run-time octave register. Note-on/note-off events go out through a valid/ready FIFO.
//  Sits between the PS/2 receiver and the tone generator / pitch-scoring logic.
// PARAMETERS
//  KEY_F..KEY_E   `kb_Z,`kb_S,`kb_X,`kb_D,`kb_C,`kb_F,`kb_V,`kb_B,`kb_H,`kb_N,`kb_J,`kb_M
//                 - scan codes of notes 1..12 (F..E)
//  OCT_UP_KEY     8'h55 - make code: octave +1 (the '=' key)
//  OCT_DN_KEY     8'h4E - make code: octave -1 (the '-' key)
//  OCT_W          3     - octave register width
//  OCT_MIN/OCT_MAX 1/6  - saturation bounds for the octave
//  OCT_RESET      4     - octave value after reset
//  EVT_DEPTH      4     - event FIFO depth in entries; power of 2, >=2
// PORTS
//  clk        in   1        system clock
//  resetn     in   1        asynchronous active-low reset
//  scan_code  in   8        byte from the PS/2 receiver
//  scan_valid in   1        1-cycle strobe; scan_code valid
//  evt_valid  out  1        FIFO non-empty
//  evt_ready  in   1        consumer pops the head when evt_valid&&evt_ready
//  evt_data   out  5+OCT_W  {on(1), octave(OCT_W), note(4)}; note 1..12
//  held_mask  out  12       bit n-1 set while note n is held
//  cur_note   out  4        most recently pressed note still held; 0 = none
//  octave     out  OCT_W    current octave
//  evt_ovf    out  1        sticky: an event was dropped because the FIFO was full
//  ovf_clr    in   1        clears evt_ovf; if it coincides with a drop, the set wins
// BEHAVIOUR
//  Reset: parser IDLE, held_mask=0, cur_note=0, octave=OCT_RESET, FIFO empty, evt_ovf=0.
//  Reset mid-stream drops any pending prefix and held notes; no note-off events are emitted.
//  Parser FSM, advances only on scan_valid:
//   - IDLE -F0-> BRK; IDLE -E0-> EXT; IDLE -other-> process as MAKE, stay IDLE.
//   - BRK -any-> process as BREAK, go to IDLE.
//   - EXT -F0-> EXTBRK; EXT -other-> ignore, go to IDLE.
//   - EXTBRK -any-> ignore, go to IDLE. Extended keys never map to notes.
//  MAKE of note n:
//   - If held: typematic repeat; no event, no state change.
//   - Else: set held bit, latch press octave for n, set cur_note=n, push {1,octave,n}.
//  BREAK of note n:
//   - If held: clear bit, push {0,latched octave of n,n}; cur_note=0 if cur_note==n.
//   - If not held: ignored.
//  Octave keys act on MAKE only; saturate at OCT_MIN/OCT_MAX; break codes ignored.
//  Held notes keep their press octave.
//  Unmapped codes: no effect besides FSM advance.
//  Latency: scan_valid in cycle N -> held_mask/cur_note/octave and evt_valid update at N+1.
//  FIFO is first-word-fall-through; evt_data is stable while evt_valid && !evt_ready.
//  Push while full: accepted if a pop happens the same cycle. Otherwise the event is
//   dropped, evt_ovf is set, and held_mask is still updated.
//  Push and pop when empty: the push lands; evt_valid=1 next cycle.
//  Pointers are log2(EVT_DEPTH)+1 bits and wrap naturally.
// CONFIGURATION
//  KB2PIANO_PANIC_EN defined:
//   - MAKE of 8'h76 (Esc) in IDLE clears held_mask and cur_note and flushes the FIFO.
//   - Then pushes one all-off event {0,octave,4'd0}; octave is unchanged.
//  KB2PIANO_PANIC_EN undefined: 8'h76 is an ordinary unmapped code.
// TESTING
//  1. Send 1A, then F0 1A, evt_ready=1 -> events {1,4,1} then {0,4,1}; held_mask 001->000;
//     cur_note 1->0.
//  2. Send 1A three times (typematic) -> exactly one note-on; held_mask=12'h001.
//  3. Press 22 (G), send 55 twice, press 21 (A), release 22
//     -> {1,4,3}, {1,6,5}, {0,4,3}; octave=6.
//     Send 55 x4 -> octave saturates at 6; 4E x9 -> saturates at 1.
//  4. Hold evt_ready=0 and press 5 distinct notes, EVT_DEPTH=4 -> 4 queued, evt_ovf=1,
//     held_mask has 5 bits. Pulse ovf_clr -> evt_ovf=0.
//  5. Send E0 1A, then E0 F0 1A -> no events; held_mask=0. Then 1A -> note-on (FSM back in IDLE).
//  6. Assert resetn=0 mid E0 F0 sequence while notes held -> all outputs at reset values;
//     next 1A yields {1,4,1}. With KB2PIANO_PANIC_EN: hold 3 notes, send 76 -> FIFO holds
//     only {0,4,0}; held_mask=0.

Source files
------------

// File: rtl/kb2piano_poly.sv
// kb2piano_poly: PS/2 set-2 scan-code parser driving a 12-note held map, an octave register
// and a FWFT note-event FIFO. Optional macro KB2PIANO_PANIC_EN enables the Esc all-notes-off.
module kb2piano_poly #(
  parameter logic [7:0] KEY_F      = 8'h1A,
  parameter logic [7:0] KEY_FS     = 8'h1B,
  parameter logic [7:0] KEY_G      = 8'h22,
  parameter logic [7:0] KEY_GS     = 8'h23,
  parameter logic [7:0] KEY_A      = 8'h21,
  parameter logic [7:0] KEY_AS     = 8'h2B,
  parameter logic [7:0] KEY_B      = 8'h2A,
  parameter logic [7:0] KEY_C      = 8'h32,
  parameter logic [7:0] KEY_CS     = 8'h33,
  parameter logic [7:0] KEY_D      = 8'h31,
  parameter logic [7:0] KEY_DS     = 8'h3B,
  parameter logic [7:0] KEY_E      = 8'h3A,
  parameter logic [7:0] OCT_UP_KEY = 8'h55,
  parameter logic [7:0] OCT_DN_KEY = 8'h4E,
  parameter int         OCT_W      = 3,
  parameter int         OCT_MIN    = 1,
  parameter int         OCT_MAX    = 6,
  parameter int         OCT_RESET  = 4,
  parameter int         EVT_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       scan_code,
  input  logic             scan_valid,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [4+OCT_W:0] evt_data,
  output logic [11:0]      held_mask,
  output logic [3:0]       cur_note,
  output logic [OCT_W-1:0] octave,
  output logic             evt_ovf,
  input  logic             ovf_clr
);
  localparam int AW = $clog2(EVT_DEPTH);
  localparam int EW = 5 + OCT_W;
  localparam logic [OCT_W-1:0] OMIN  = OCT_W'(OCT_MIN);
  localparam logic [OCT_W-1:0] OMAX  = OCT_W'(OCT_MAX);
  localparam logic [OCT_W-1:0] ORST  = OCT_W'(OCT_RESET);
  localparam logic [OCT_W-1:0] OONE  = OCT_W'(1);
  localparam logic [AW:0]      PONE  = (AW+1)'(1);
  localparam logic [7:0]       BRK_CODE = 8'hF0;
  localparam logic [7:0]       EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} pstate_t;

  pstate_t          state;
  logic [OCT_W-1:0] press_oct [12];
  logic [EW-1:0]    mem [EVT_DEPTH];
  logic [AW:0]      wptr, rptr;

  logic [3:0]    note, idx;
  logic [15:0]   held_ext;
  logic          held_n, is_make, is_brk, do_on, do_off, oct_up, oct_dn, panic;
  logic          push_req, push_ok, pop, full;
  logic [EW-1:0] push_data;

  function automatic logic [3:0] note_of(input logic [7:0] c);
    case (c)
      KEY_F:   return 4'd1;
      KEY_FS:  return 4'd2;
      KEY_G:   return 4'd3;
      KEY_GS:  return 4'd4;
      KEY_A:   return 4'd5;
      KEY_AS:  return 4'd6;
      KEY_B:   return 4'd7;
      KEY_C:   return 4'd8;
      KEY_CS:  return 4'd9;
      KEY_D:   return 4'd10;
      KEY_DS:  return 4'd11;
      KEY_E:   return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  assign note     = note_of(scan_code);
  assign idx      = note - 4'd1;
  // Zero-padded so an unmapped code (idx wraps to 15) reads as "not held".
  assign held_ext = {4'd0, held_mask};
  assign held_n   = (note != 4'd0) && held_ext[idx];

  assign is_make  = scan_valid && (state == IDLE) && (scan_code != BRK_CODE) && (scan_code != EXT_CODE);
  assign is_brk   = scan_valid && (state == BRK);
  assign do_on    = is_make && (note != 4'd0) && !held_n;
  assign do_off   = is_brk && held_n;
  assign oct_up   = is_make && (scan_code == OCT_UP_KEY) && (octave < OMAX);
  assign oct_dn   = is_make && (scan_code == OCT_DN_KEY) && (octave > OMIN);

`ifdef KB2PIANO_PANIC_EN
  assign panic = is_make && (scan_code == 8'h76);
`else
  assign panic = 1'b0;
`endif

  assign push_req  = do_on || do_off;
  assign push_data = do_on ? {1'b1, octave, note} : {1'b0, press_oct[idx], note};

  assign evt_valid = (wptr != rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop       = evt_valid && evt_ready;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign evt_data  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      held_mask <= '0;
      cur_note  <= '0;
      octave    <= ORST;
      evt_ovf   <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      for (int i = 0; i < 12; i++) press_oct[i] <= '0;
    end else begin
      if (scan_valid) begin
        case (state)
          IDLE:    state <= (scan_code == BRK_CODE) ? BRK :
                            (scan_code == EXT_CODE) ? EXT : IDLE;
          EXT:     state <= (scan_code == BRK_CODE) ? EXTBRK : IDLE;
          default: state <= IDLE;
        endcase
      end

      if (do_on) begin
        held_mask[idx] <= 1'b1;
        press_oct[idx] <= octave;
        cur_note       <= note;
      end
      if (do_off) begin
        held_mask[idx] <= 1'b0;
        if (cur_note == note) cur_note <= 4'd0;
      end

      if (oct_up) octave <= octave + OONE;
      if (oct_dn) octave <= octave - OONE;

      // Panic empties the queue and leaves exactly the all-off event behind.
      if (panic) begin
        held_mask <= '0;
        cur_note  <= '0;
        rptr      <= wptr;
        wptr      <= wptr + PONE;
      end else begin
        if (push_ok) wptr <= wptr + PONE;
        if (pop)     rptr <= rptr + PONE;
      end

      if (push_req && !push_ok) evt_ovf <= 1'b1;
      else if (ovf_clr)         evt_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (panic)        mem[wptr[AW-1:0]] <= {1'b0, octave, 4'd0};
    else if (push_ok) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_kb2piano_poly.sv
// Randomized + directed bench for kb2piano_poly against a queue-based behavioural model.
module tb_kb2piano_poly;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, resetn = 1'b0, scan_valid = 1'b0, evt_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       evt_valid, evt_ovf;
  logic [7:0] evt_data;
  logic [11:0] held_mask;
  logic [3:0]  cur_note;
  logic [2:0]  octave;

  kb2piano_poly dut (
    .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .held_mask(held_mask), .cur_note(cur_note), .octave(octave),
    .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int keys [12] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2B, 8'h2A, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A};

  // Reference model: prefix flags, held flags, per-note press octave, event queue.
  bit m_held [12];
  int m_poct [12];
  int m_cur, m_oct;
  int m_q [$];
  bit m_ovf, m_f0, m_e0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int note_of(input int c);
    for (int i = 0; i < 12; i++) if (keys[i] == c) return i + 1;
    return 0;
  endfunction

  function automatic int ev(input int on, input int oc, input int n);
    return on * 128 + oc * 16 + n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin m_held[i] = 0; m_poct[i] = 0; end
    m_cur = 0; m_oct = 4; m_q.delete(); m_ovf = 0; m_f0 = 0; m_e0 = 0;
  endtask

  task automatic model_step(input bit sv, input int code, input bit rdy, input bit clr);
    bit pop, push, panic;
    int e, n;
    pop = (m_q.size() > 0) && rdy;
    push = 0; panic = 0; e = 0;
    n = note_of(code);
    if (sv) begin
      if (!m_f0 && !m_e0) begin
        if (code == 8'hF0) m_f0 = 1;
        else if (code == 8'hE0) m_e0 = 1;
        else if (n != 0) begin
          if (!m_held[n-1]) begin
            m_held[n-1] = 1; m_poct[n-1] = m_oct; m_cur = n;
            push = 1; e = ev(1, m_oct, n);
          end
        end
        else if (code == 8'h55) m_oct = (m_oct < 6) ? m_oct + 1 : 6;
        else if (code == 8'h4E) m_oct = (m_oct > 1) ? m_oct - 1 : 1;
`ifdef KB2PIANO_PANIC_EN
        else if (code == 8'h76) begin
          for (int i = 0; i < 12; i++) m_held[i] = 0;
          m_cur = 0; panic = 1;
        end
`endif
      end else if (m_f0 && !m_e0) begin
        if (n != 0 && m_held[n-1]) begin
          m_held[n-1] = 0; push = 1; e = ev(0, m_poct[n-1], n);
          if (m_cur == n) m_cur = 0;
        end
        m_f0 = 0;
      end else if (m_e0 && !m_f0) begin
        if (code == 8'hF0) m_f0 = 1; else m_e0 = 0;
      end else begin
        m_e0 = 0; m_f0 = 0;
      end
    end
    if (panic) begin
      m_q.delete(); m_q.push_back(ev(0, m_oct, 0));
      if (clr) m_ovf = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push && m_q.size() >= DEPTH) m_ovf = 1;
      else begin
        if (push) m_q.push_back(e);
        if (clr) m_ovf = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [11:0] hm;
    for (int i = 0; i < 12; i++) hm[i] = m_held[i];
    chk("evt_valid", evt_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("evt_data", evt_data, m_q[0]);
    chk("held_mask", held_mask, hm);
    chk("cur_note", cur_note, m_cur);
    chk("octave", octave, m_oct);
    chk("evt_ovf", evt_ovf, m_ovf);
  endtask

  task automatic step(input bit sv, input int code, input bit rdy, input bit clr);
    @(negedge clk);
    check_outputs();
    scan_valid = sv; scan_code = code[7:0]; evt_ready = rdy; ovf_clr = clr;
    model_step(sv, code, rdy, clr);
  endtask

  task automatic send(input int code, input bit rdy);
    step(1, code, rdy, 0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, rdy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    resetn = 0; scan_valid = 0; evt_ready = 0; ovf_clr = 0;
    model_reset();
    @(negedge clk);
    check_outputs();
    chk("rst_octave", octave, 4);
    chk("rst_held", held_mask, 0);
    chk("rst_valid", evt_valid, 0);
    resetn = 1;
  endtask

  initial begin
    int exp3 [3];
    int r, code, rdy_mode;
    model_reset();

    // 1: single press/release
    do_reset();
    send(8'h1A, 1); idle(1);
    chk("t1_on", evt_data, 8'hC1); chk("t1_held1", held_mask, 12'h001); chk("t1_cur1", cur_note, 1);
    send(8'hF0, 1); send(8'h1A, 1); idle(1);
    chk("t1_off", evt_data, 8'h41); chk("t1_held0", held_mask, 0); chk("t1_cur0", cur_note, 0);
    idle(1);

    // 2: typematic repeat
    do_reset();
    send(8'h1A, 0); send(8'h1A, 0); send(8'h1A, 0); idle(0);
    chk("t2_held", held_mask, 12'h001); chk("t2_head", evt_data, 8'hC1);
    idle(1); idle(0);
    chk("t2_single", evt_valid, 0);

    // 3: octave latch per note, saturation
    do_reset();
    send(8'h22, 0); send(8'h55, 0); send(8'h55, 0); send(8'h21, 0);
    send(8'hF0, 0); send(8'h22, 0); idle(0);
    chk("t3_oct6", octave, 6);
    exp3 = '{8'hC3, 8'hE5, 8'h43};
    for (int i = 0; i < 3; i++) begin
      chk("t3_evt", evt_data, exp3[i]);
      idle(1); idle(0);
    end
    for (int i = 0; i < 4; i++) send(8'h55, 1);
    idle(1); chk("t3_sat_hi", octave, 6);
    for (int i = 0; i < 9; i++) send(8'h4E, 1);
    idle(1); chk("t3_sat_lo", octave, 1);

    // 4: overflow and sticky clear
    do_reset();
    for (int i = 0; i < 5; i++) send(keys[i], 0);
    idle(0);
    chk("t4_ovf", evt_ovf, 1); chk("t4_held5", held_mask, 12'h01F); chk("t4_head", evt_data, 8'hC1);
    step(0, 0, 0, 1); idle(0);
    chk("t4_ovf_clr", evt_ovf, 0);

    // 5: extended codes are ignored
    do_reset();
    send(8'hE0, 1); send(8'h1A, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h1A, 1); idle(1);
    chk("t5_held0", held_mask, 0); chk("t5_noevt", evt_valid, 0);
    send(8'h1A, 0); idle(0);
    chk("t5_on", evt_data, 8'hC1); chk("t5_held1", held_mask, 12'h001);

    // 6: reset mid-sequence
    do_reset();
    send(8'h1A, 1); send(8'h1B, 1); send(8'hE0, 1); send(8'hF0, 1);
    do_reset();
    send(8'h1A, 0); idle(0);
    chk("t6_on", evt_data, 8'hC1);

`ifdef KB2PIANO_PANIC_EN
    do_reset();
    send(8'h1A, 0); send(8'h22, 0); send(8'h21, 0); send(8'h76, 0); idle(0);
    chk("pan_held", held_mask, 0); chk("pan_evt", evt_data, 8'h40);
    idle(1); idle(0);
    chk("pan_only", evt_valid, 0);
`endif

    // Random traffic against the model
    do_reset();
    rdy_mode = 1;
    for (int t = 0; t < 4000; t++) begin
      if (t % 60 == 0) rdy_mode = $urandom_range(0, 2);
      if (t % 700 == 699) do_reset();
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: code = keys[$urandom_range(0, 11)];
        5:             code = 8'hF0;
        6:             code = 8'hE0;
        7:             code = ($urandom_range(0, 1) != 0) ? 8'h55 : 8'h4E;
        8:             code = 8'h76;
        default:       code = $urandom_range(0, 255);
      endcase
      step($urandom_range(0, 1), code,
           (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end
    @(negedge clk);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
